i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 143 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C master between two requesters.
// Optional stall abort is built when I2C_ARB_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | no owner; arbitrate between req0 and req1
// GRANT     | owner latched, m_start pulsed to the master
// WAIT_BUSY | waiting for the master to raise m_busy
// WAIT_DONE | waiting for the master to drop m_busy
// RELEASE   | ack (and err) to the owner, last-served pointer updated
module i2c_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       err,
   output logic [1:0] gnt,
   output logic [7:0] m_address,
   output logic [7:0] m_data,
   output logic       m_start,
   input  logic       m_busy
);
   typedef enum logic [2:0] {IDLE, GRANT, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

   state_t     state_q, state_d;
   logic [1:0] gnt_q, gnt_d;
   logic [7:0] addr_q, addr_d, data_q, data_d;
   logic       start_q, start_d, ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
   logic       last1_q, last1_d;   // 1: requester 1 was served last
   logic       win1, timeout;

   assign win1 = req1 && (!req0 || !last1_q);

`ifdef I2C_ARB_TIMEOUT_EN
   logic        waiting;
   logic [15:0] cnt_q, cnt_d;

   assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == GRANT)
         cnt_d = '0;
      else if (waiting)
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // cnt_q counts completed wait cycles, so the abort edge is the TIMEOUT_CYCLES-th one
   assign timeout = waiting && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last1_d = last1_q;
      start_d = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d = GRANT;
               start_d = 1'b1;
               gnt_d   = win1 ? 2'b10 : 2'b01;
               addr_d  = win1 ? addr1 : addr0;
               data_d  = win1 ? data1 : data0;
            end
         end
         GRANT: state_d = WAIT_BUSY;
         WAIT_BUSY, WAIT_DONE: begin
            if (timeout) begin
               state_d = RELEASE;
               ack0_d  = gnt_q[0];
               ack1_d  = gnt_q[1];
               err_d   = 1'b1;
            end else if (state_q == WAIT_BUSY && m_busy) begin
               state_d = WAIT_DONE;
            end else if (state_q == WAIT_DONE && !m_busy) begin
               state_d = RELEASE;
               ack0_d  = gnt_q[0];
               ack1_d  = gnt_q[1];
            end
         end
         RELEASE: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            last1_d = gnt_q[1];
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         addr_q  <= 8'h00;
         data_q  <= 8'h00;
         last1_q <= 1'b1;
         start_q <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last1_q <= last1_d;
         start_q <= start_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err_q   <= err_d;
      end
   end

   assign gnt       = gnt_q;
   assign m_address = addr_q;
   assign m_data    = data_q;
   assign m_start   = start_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign err       = err_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and values.
module tb_i2c_arbiter;
   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1;
   logic [7:0] addr0, addr1, data0, data1;
   logic       m_busy;
   logic       ack0, ack1, err, m_start;
   logic [1:0] gnt;
   logic [7:0] m_address, m_data;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_ack0 = 0;
   int n_ack1 = 0;
   int fall_cyc = 0;
   bit busy_prev = 1'b0;
   bit busy_en;
   int busy_delay = 3;
   int busy_hold = 20;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO = 4096;

   i2c_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1),
      .data0(data0), .data1(data1),
      .ack0(ack0), .ack1(ack1), .err(err),
      .gnt(gnt), .m_address(m_address), .m_data(m_data),
      .m_start(m_start), .m_busy(m_busy)
   );

`ifdef I2C_ARB_TIMEOUT_EN
   logic       t_req;
   logic       t_zero = 1'b0;
   logic       t_ack0, t_ack1, t_err, t_start;
   logic [1:0] t_gnt;
   logic [7:0] t_addr, t_data;

   i2c_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
      .clk(clk), .reset(reset),
      .req0(t_req), .req1(t_zero),
      .addr0(8'h11), .addr1(8'h22),
      .data0(8'h33), .data1(8'h44),
      .ack0(t_ack0), .ack1(t_ack1), .err(t_err),
      .gnt(t_gnt), .m_address(t_addr), .m_data(t_data),
      .m_start(t_start), .m_busy(t_zero)
   );
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference model: one transaction at a time, phases counted in plain integers.
   int         md_ph, md_own, md_last, md_wait;
   logic [1:0] md_gnt;
   logic [7:0] md_addr, md_data;
   logic       md_start, md_ack0, md_ack1, md_err;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         md_ph = 0; md_own = -1; md_last = 1; md_wait = 0;
         md_gnt = 2'b00; md_addr = 8'h00; md_data = 8'h00;
         md_start = 1'b0; md_ack0 = 1'b0; md_ack1 = 1'b0; md_err = 1'b0;
      end else begin
         md_start = 1'b0; md_ack0 = 1'b0; md_ack1 = 1'b0; md_err = 1'b0;
         case (md_ph)
            0: if (req0 || req1) begin
                  md_own   = (req0 && req1) ? 1 - md_last : (req1 ? 1 : 0);
                  md_gnt   = 2'(1 << md_own);
                  md_addr  = (md_own == 1) ? addr1 : addr0;
                  md_data  = (md_own == 1) ? data1 : data0;
                  md_start = 1'b1;
                  md_ph    = 1;
               end
            1: begin md_ph = 2; md_wait = 0; end
            2, 3: begin
               md_wait++;
               if (TO_EN && md_wait >= TO) begin
                  md_ph = 4; md_err = 1'b1;
                  md_ack0 = (md_own == 0); md_ack1 = (md_own == 1);
               end else if (md_ph == 2 && m_busy) begin
                  md_ph = 3;
               end else if (md_ph == 3 && !m_busy) begin
                  md_ph = 4;
                  md_ack0 = (md_own == 0); md_ack1 = (md_own == 1);
               end
            end
            default: begin md_last = md_own; md_own = -1; md_gnt = 2'b00; md_ph = 0; end
         endcase
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         checks++;
         if ({gnt, m_address, m_data, m_start, ack0, ack1, err} !==
             {md_gnt, md_addr, md_data, md_start, md_ack0, md_ack1, md_err}) begin
            errors++;
            $display("FAIL model cyc=%0d got gnt=%b addr=%h data=%h start=%b ack0=%b ack1=%b err=%b want gnt=%b addr=%h data=%h start=%b ack0=%b ack1=%b err=%b",
                     cyc, gnt, m_address, m_data, m_start, ack0, ack1, err,
                     md_gnt, md_addr, md_data, md_start, md_ack0, md_ack1, md_err);
         end
      end
      if (ack0 === 1'b1) n_ack0++;
      if (ack1 === 1'b1) n_ack1++;
      if (busy_prev && !m_busy) fall_cyc = cyc;
      busy_prev = m_busy;
   end

   // Bench-side I2C master: busy_delay cycles after m_start, hold m_busy for busy_hold cycles.
   initial begin
      m_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (m_start && busy_en) begin
            repeat (busy_delay) @(posedge clk);
            #1 m_busy = 1'b1;
            repeat (busy_hold) @(posedge clk);
            #1 m_busy = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cyc=%0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wait_start(input string nm, output int c);
      int n = 0;
      do begin @(negedge clk); n++; end while (m_start !== 1'b1 && n < 300);
      if (m_start !== 1'b1) chk({nm, "_start_timeout"}, 32'(m_start), 32'h1);
      c = cyc;
   endtask

   task automatic wait_any(input string nm, output int c);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(ack0 === 1'b1 || ack1 === 1'b1) && n < 300);
      if (!(ack0 === 1'b1 || ack1 === 1'b1)) chk({nm, "_ack_timeout"}, 32'({ack1, ack0}), 32'h1);
      c = cyc;
   endtask

   task automatic wait_busy(input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end while (m_busy !== 1'b1 && n < 100);
      if (m_busy !== 1'b1) chk({nm, "_busy_timeout"}, 32'(m_busy), 32'h1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int rc, sc, ac, a0;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      addr0 = 8'h00; addr1 = 8'h00; data0 = 8'h00; data1 = 8'h00;
      busy_en = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
      t_req = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 chk("rst_outputs", 32'({gnt, m_address, m_data, m_start, ack0, ack1, err}), 32'h0);
      @(posedge clk); #1 reset = 1'b0;

      // single requester, master busy 3 cycles after start for 20 cycles
      @(posedge clk); #1 req0 = 1'b1; addr0 = 8'hA0; data0 = 8'h55; rc = cyc;
      wait_start("s1", sc);
      chk("s1_start_lat", sc - rc, 1);
      chk("s1_addr", 32'(m_address), 32'hA0);
      chk("s1_data", 32'(m_data), 32'h55);
      chk("s1_gnt", 32'(gnt), 32'h1);
      a0 = n_ack0;
      wait_any("s1", ac); req0 = 1'b0;
      chk("s1_ack_is0", 32'({ack1, ack0}), 32'h1);
      chk("s1_ack_lat", ac - fall_cyc, 1);
      chk("s1_start_to_ack", ac - sc, 24);
      chk("s1_err", 32'(err), 32'h0);
      repeat (3) @(negedge clk);
      chk("s1_ack_once", n_ack0 - a0, 1);

      // tie after reset: requester 0 first, then requester 1
      do_reset();
      @(posedge clk); #1 req0 = 1'b1; req1 = 1'b1;
      addr0 = 8'h10; addr1 = 8'h20; data0 = 8'h01; data1 = 8'h02;
      wait_any("s2a", ac);
      chk("s2_first_ack", 32'({ack1, ack0}), 32'h1);
      chk("s2_first_gnt", 32'(gnt), 32'h1);
      chk("s2_first_addr", 32'(m_address), 32'h10);
      req0 = 1'b0;
      wait_any("s2b", ac);
      chk("s2_second_ack", 32'({ack1, ack0}), 32'h2);
      chk("s2_second_gnt", 32'(gnt), 32'h2);
      chk("s2_second_data", 32'(m_data), 32'h02);
      req1 = 1'b0;

      // req1 arrives while requester 0 is in WAIT_DONE
      @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h30; data0 = 8'h33;
      wait_busy("s3");
      repeat (2) @(posedge clk);
      #1 req1 = 1'b1; addr1 = 8'h40; data1 = 8'h44;
      wait_any("s3a", ac);
      chk("s3_ack_is0", 32'({ack1, ack0}), 32'h1);
      chk("s3_addr_held", 32'(m_address), 32'h30);
      req0 = 1'b0;
      wait_start("s3", sc);
      chk("s3_regrant_lat", sc - ac, 2);
      chk("s3_gnt1", 32'(gnt), 32'h2);
      chk("s3_addr1", 32'(m_address), 32'h40);
      wait_any("s3b", ac);
      chk("s3_ack_is1", 32'({ack1, ack0}), 32'h2);
      req1 = 1'b0;

      // req0 dropped during WAIT_DONE
      @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h60; data0 = 8'h66;
      wait_busy("s4");
      repeat (2) @(posedge clk);
      #1 req0 = 1'b0;
      a0 = n_ack0;
      wait_any("s4", ac);
      chk("s4_ack_is0", 32'({ack1, ack0}), 32'h1);
      repeat (4) @(negedge clk);
      chk("s4_ack_once", n_ack0 - a0, 1);

      // master never responds: no ack within 120 cycles (timeout is far away or absent)
      busy_en = 1'b0;
      @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h70; data0 = 8'h77;
      wait_start("s5", sc);
      a0 = n_ack0 + n_ack1;
      repeat (120) @(negedge clk);
      chk("s5_no_ack", n_ack0 + n_ack1 - a0, 0);
      chk("s5_gnt_held", 32'(gnt), 32'h1);
      req0 = 1'b0;
      do_reset();
      busy_en = 1'b1;

`ifdef I2C_ARB_TIMEOUT_EN
      // TIMEOUT_CYCLES=16 instance: ack with err 17 cycles after m_start
      @(posedge clk); #1 t_req = 1'b1;
      begin
         int n = 0;
         do begin @(negedge clk); n++; end while (t_start !== 1'b1 && n < 100);
         chk("to_start_seen", 32'(t_start), 32'h1);
         sc = cyc; n = 0;
         do begin @(negedge clk); n++; end while (t_ack0 !== 1'b1 && n < 100);
         chk("to_ack_seen", 32'(t_ack0), 32'h1);
         chk("to_lat", cyc - sc, 17);
         chk("to_err", 32'(t_err), 32'h1);
      end
      t_req = 1'b0;
`endif

      // reset during WAIT_DONE aborts with no ack; pointer returns to favour requester 0
      @(posedge clk); #1 req0 = 1'b1; addr0 = 8'h80; data0 = 8'h88;
      wait_busy("s6");
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1 chk("s6_rst_outputs", 32'({gnt, m_address, m_data, m_start, ack0, ack1, err}), 32'h0);
      a0 = n_ack0 + n_ack1;
      req0 = 1'b0;
      begin
         int n = 0;
         while (m_busy && n < 100) begin @(negedge clk); n++; end
      end
      chk("s6_no_ack", n_ack0 + n_ack1 - a0, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 req1 = 1'b1; req0 = 1'b1;
      addr0 = 8'h90; addr1 = 8'hA1; data0 = 8'h09; data1 = 8'h0A;
      wait_start("s6", sc);
      chk("s6_gnt0", 32'(gnt), 32'h1);
      chk("s6_addr0", 32'(m_address), 32'h90);
      wait_any("s6a", ac);
      chk("s6_ack_is0", 32'({ack1, ack0}), 32'h1);
      req0 = 1'b0;
      wait_any("s6b", ac);
      chk("s6_ack_is1", 32'({ack1, ack0}), 32'h2);
      req1 = 1'b0;

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
